alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control-side counterpart of the ALU datapath: accepts one ALU-class instruction (opcode 1000 r fff) from the fetch/decode unit.
- Drives the 3-bit function select and enable into the ALU, waits a programmable settle time that models relay settling, then writes the result to register A or D.
- Updates the Sign/Carry/Zero condition flags consumed by conditional jumps.
- Sits between the instruction decoder and the register file / ALU.

Parameters:
- SETTLE_CYCLES, 2, cycles alu_en is held before the result is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  decoder presents an instruction
- instr_ready  output  1  sequencer can accept an instruction
- instr  input  8  instruction byte; [7:4] opcode, [3] dest (0=A, 1=D), [2:0] function
- alu_fn  output  3  function select to the ALU decoder
- alu_en  output  1  ALU enable (result bus driven)
- alu_result  input  8  ALU result bus
- alu_carry  input  1  adder/shifter carry out
- dest_we_a  output  1  write strobe, register A
- dest_we_d  output  1  write strobe, register D
- dest_data  output  8  write data to register file
- flag_sign  output  1  registered Sign flag
- flag_carry  output  1  registered Carry flag
- flag_zero  output  1  registered Zero flag
- illegal  output  1  one-cycle pulse: accepted instruction had opcode != 4'b1000
- done  output  1  one-cycle pulse: instruction retired

Behaviour:
- Clocking and reset: all state on rising clk; reset is synchronous, active-high.
  - Reset values: state IDLE, instr_ready=1, alu_fn=0, alu_en=0, dest_we_a=0, dest_we_d=0, dest_data=0, all flags 0, illegal=0, done=0.
  - Reset mid-operation aborts with no write and no flag change that cycle; reset has priority over every other event.
- States: IDLE, EXEC, WRITE.
- IDLE:
  - instr_ready=1.
  - A handshake occurs when instr_valid and instr_ready are both high.
  - Legal opcode: latch dest and function, then go to EXEC with counter=SETTLE_CYCLES-1.
  - Illegal opcode: pulse illegal next cycle, stay IDLE; no ALU activity, no write, flags unchanged.
- EXEC:
  - instr_ready=0; alu_fn holds the latched function.
  - alu_en=1 for functions 000-110 and 0 for 111 (CLR; the result bus reads 0).
  - The counter decrements each cycle. On the cycle it reads 0, alu_result and alu_carry are captured into dest_data and the flags, and the state goes to WRITE.
- WRITE:
  - The selected dest_we_* is 1 for exactly one cycle, with dest_data stable; done=1.
  - alu_en=0; next state is IDLE.
- Latency: with the handshake in cycle N, alu_en is high in cycles N+1..N+SETTLE_CYCLES, the write strobe is in cycle N+1+SETTLE_CYCLES, and the next handshake is possible in cycle N+2+SETTLE_CYCLES.
- Throughput: one instruction per SETTLE_CYCLES+2 cycles.
- instr_valid while instr_ready=0 is ignored. The decoder must hold instr stable until the handshake; the sequencer latches instr at the handshake.
- Function codes: 000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 CLR.
- Flags, updated only at EXEC exit, never on illegal or abort:
  - Zero = (result == 0).
  - Sign = result[7].
  - Carry = alu_carry for ADD/INC/SHL, forced to 0 for every other function.
- alu_fn keeps its last value outside EXEC; only alu_en qualifies it.
- Wrap-around (e.g. INC of 0xFF) is the ALU's job: the sequencer writes the 8-bit result as given and carry as given.
- SETTLE_CYCLES outside 1..15 is an elaboration-time error.

Decomposition:
- Shared package hpr_alu_pkg:
  - enum alu_fn_e (ADD..CLR, 3 bits)
  - constant OPC_ALU = 4'b1000
  - enum seq_state_e {IDLE, EXEC, WRITE}
  - function fn_sets_carry(alu_fn_e)
- One sub-module, alu_flag_register: captures Sign/Carry/Zero with a load enable and synchronous reset. Reused later by the jump-condition logic.

Test Plan:
- ADD, dest A (instr=0x80), SETTLE_CYCLES=2, alu_result=0x00, alu_carry=1 → dest_we_a exactly in cycle N+3, dest_data=0x00, zero=1, carry=1, sign=0, done in N+3, instr_ready high again in N+4.
- AND, dest D (instr=0x8A), alu_result=0x80, alu_carry=1 → dest_we_d only, dest_data=0x80, sign=1, zero=0, carry=0 (forced).
- CLR (instr=0x87) → alu_en stays 0 throughout EXEC, dest_we_a with dest_data=0x00, zero=1.
- Illegal byte instr=0x12 → illegal pulses one cycle, no alu_en, no write strobe, flags keep prior values, instr_ready remains 1.
- Reset asserted in the second EXEC cycle of an INC → no write strobe, all outputs at reset values next cycle, flags 0, next instruction accepted normally.
- Back-to-back instr_valid held high with instructions 0x81, 0x8E → exactly two handshakes, spaced 4 cycles apart, writes in order A then D, no instruction dropped or duplicated.

Source files
------------

// File: rtl/hpr_alu_pkg.sv
// hpr_alu_pkg: shared ALU function codes, opcode constant, sequencer states and carry helper
package hpr_alu_pkg;
  typedef enum logic [2:0] {ADD, INC, AND, OR, XOR, NOT, SHL, CLR} alu_fn_e;
  localparam logic [3:0] OPC_ALU = 4'b1000;
  typedef enum logic [1:0] {IDLE, EXEC, WRITE} seq_state_e;
  function automatic logic fn_sets_carry(alu_fn_e f);
    return f inside {ADD, INC, SHL};
  endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: decoder handshake, ALU control/result and register-file write bus
// slave  = sequencer side (receives instr_valid/instr/alu_result/alu_carry)
// master = decoder/ALU/regfile side (receives everything the sequencer drives)
interface alu_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [2:0] alu_fn;
  logic       alu_en;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       dest_we_a;
  logic       dest_we_d;
  logic [7:0] dest_data;
  logic       flag_sign;
  logic       flag_carry;
  logic       flag_zero;
  logic       illegal;
  logic       done;
  modport slave (
    input  instr_valid, instr, alu_result, alu_carry,
    output instr_ready, alu_fn, alu_en, dest_we_a, dest_we_d, dest_data,
           flag_sign, flag_carry, flag_zero, illegal, done
  );
  modport master (
    output instr_valid, instr, alu_result, alu_carry,
    input  instr_ready, alu_fn, alu_en, dest_we_a, dest_we_d, dest_data,
           flag_sign, flag_carry, flag_zero, illegal, done
  );
endinterface

// File: rtl/alu_flag_register.sv
// alu_flag_register: Sign/Carry/Zero condition flags with load enable and sync reset
// clk, reset : clock, synchronous active-high reset
// load       : capture *_in this cycle
// sign/carry/zero : registered flags
module alu_flag_register (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic sign_in,
  input  logic carry_in,
  input  logic zero_in,
  output logic sign,
  output logic carry,
  output logic zero
);
  always_ff @(posedge clk)
    if (reset) {sign, carry, zero} <= 3'b000;
    else if (load) {sign, carry, zero} <= {sign_in, carry_in, zero_in};
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts ALU-class instructions, drives the ALU for SETTLE_CYCLES, writes A or D and updates flags
// clk, reset : clock, synchronous active-high reset
// bus        : decoder handshake, ALU control/result, regfile write, flags, illegal/done pulses
module alu_sequencer
  import hpr_alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be within 1..15");
  end
  seq_state_e state_q, state_d;
  logic [3:0] cnt_q;
  alu_fn_e    fn_q;
  logic       dest_q;
  logic [7:0] data_q;
  logic       illegal_q;
  logic       hs, legal, cap;
  assign hs    = bus.instr_valid && state_q == IDLE;
  assign legal = bus.instr[7:4] == OPC_ALU;
  // result and carry are sampled on the last settle cycle, while alu_en is still high
  assign cap   = state_q == EXEC && cnt_q == 4'd0;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (hs && legal ? EXEC : IDLE) :
              state_q == EXEC ? (cap ? WRITE : EXEC) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      fn_q      <= ADD;
      dest_q    <= 1'b0;
      data_q    <= 8'h00;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= hs && !legal;
      if (hs && legal) begin
        fn_q   <= alu_fn_e'(bus.instr[2:0]);
        dest_q <= bus.instr[3];
        cnt_q  <= 4'(SETTLE_CYCLES - 1);
      end else if (state_q == EXEC) cnt_q <= cnt_q - 4'd1;
      if (cap) data_q <= bus.alu_result;
    end
  alu_flag_register u_flags (
    .clk      (clk),
    .reset    (reset),
    .load     (cap),
    .sign_in  (bus.alu_result[7]),
    .carry_in (fn_sets_carry(fn_q) && bus.alu_carry),
    .zero_in  (bus.alu_result == 8'h00),
    .sign     (bus.flag_sign),
    .carry    (bus.flag_carry),
    .zero     (bus.flag_zero)
  );
  assign bus.instr_ready = state_q == IDLE;
  assign bus.alu_fn      = fn_q;
  // CLR leaves the ALU disabled so the result bus reads zero
  assign bus.alu_en      = state_q == EXEC && fn_q != CLR;
  assign bus.dest_we_a   = state_q == WRITE && !dest_q;
  assign bus.dest_we_d   = state_q == WRITE && dest_q;
  assign bus.dest_data   = data_q;
  assign bus.illegal     = illegal_q;
  assign bus.done        = state_q == WRITE;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench with a behavioural ALU and transaction-level reference
module tb_alu_sequencer;
  localparam int S = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] op_a = 8'h00, op_b = 8'h00;
  logic [8:0] alu_out;
  logic m_s = 1'b0, m_c = 1'b0, m_z = 1'b0;
  int total = 0, bad = 0;
  alu_sequencer_if bus ();
  alu_sequencer #(.SETTLE_CYCLES(S)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [8:0] alu_model(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} + 9'd1;
      3'd2: return {b[0], a & b};
      3'd3: return {b[0], a | b};
      3'd4: return {b[0], a ^ b};
      3'd5: return {b[0], ~a};
      3'd6: return {a, 1'b0};
      default: return 9'd0;
    endcase
  endfunction
  assign alu_out = alu_model(bus.alu_fn, op_a, op_b);
  assign bus.alu_result = bus.alu_en ? alu_out[7:0] : 8'h00;
  assign bus.alu_carry  = bus.alu_en & alu_out[8];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_flags(input string tag);
    check(tag, {bus.flag_sign, bus.flag_carry, bus.flag_zero}, {m_s, m_c, m_z});
  endtask
  task automatic expect_result(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b,
                               output logic [7:0] r, output logic c);
    logic [8:0] v;
    v = alu_model(ins[2:0], a, b);
    r = ins[2:0] == 3'd7 ? 8'h00 : v[7:0];
    c = (ins[2:0] == 3'd0 || ins[2:0] == 3'd1 || ins[2:0] == 3'd6) ? v[8] : 1'b0;
  endtask
  task automatic run_instr(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic c;
    int n;
    op_a = a;
    op_b = b;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_wait", bus.instr_ready, 1);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr = 8'($urandom);
    if (ins[7:4] != 4'b1000) begin
      check("ill_pulse", bus.illegal, 1);
      check("ill_ready", bus.instr_ready, 1);
      check("ill_en", bus.alu_en, 0);
      check("ill_we", {bus.dest_we_a, bus.dest_we_d, bus.done}, 0);
      check_flags("ill_flags");
      step();
      check("ill_clear", bus.illegal, 0);
      check("ill_we2", {bus.dest_we_a, bus.dest_we_d, bus.alu_en}, 0);
    end else begin
      expect_result(ins, a, b, r, c);
      for (int i = 0; i < S; i++) begin
        check("exec_ready", bus.instr_ready, 0);
        check("exec_en", bus.alu_en, ins[2:0] != 3'd7);
        check("exec_fn", bus.alu_fn, ins[2:0]);
        check("exec_we", {bus.dest_we_a, bus.dest_we_d, bus.done}, 0);
        check_flags("exec_flags");
        step();
      end
      m_s = r[7];
      m_z = r == 8'h00;
      m_c = c;
      check("wr_we", {bus.dest_we_a, bus.dest_we_d}, {!ins[3], ins[3]});
      check("wr_done", bus.done, 1);
      check("wr_en", bus.alu_en, 0);
      check("wr_data", bus.dest_data, r);
      check_flags("wr_flags");
      step();
      check("post_ready", bus.instr_ready, 1);
      check("post_pulses", {bus.dest_we_a, bus.dest_we_d, bus.done, bus.illegal}, 0);
      check("post_fn", bus.alu_fn, ins[2:0]);
    end
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, bus.instr_ready, 1);
    check({tag, "_fn"}, bus.alu_fn, 0);
    check({tag, "_outs"}, {bus.alu_en, bus.dest_we_a, bus.dest_we_d, bus.illegal, bus.done}, 0);
    check({tag, "_data"}, bus.dest_data, 0);
    check({tag, "_flags"}, {bus.flag_sign, bus.flag_carry, bus.flag_zero}, 0);
  endtask
  initial begin
    int hs_c[$];
    logic wq[$];
    logic hs_pend;
    logic [7:0] r, ins;
    logic c;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    step();
    step();
    check_reset_state("rst");
    reset = 1'b0;
    step();
    run_instr(8'h80, 8'h80, 8'h80);
    run_instr(8'h8A, 8'h80, 8'hFF);
    run_instr(8'h87, 8'h5A, 8'hA5);
    run_instr(8'h12, 8'h11, 8'h22);
    op_a = 8'h3C;
    op_b = 8'h01;
    bus.instr = 8'h81;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    check("abort_en", bus.alu_en, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("abort");
    m_s = 1'b0;
    m_c = 1'b0;
    m_z = 1'b0;
    step();
    check("abort_nowr", {bus.dest_we_a, bus.dest_we_d, bus.done}, 0);
    run_instr(8'h81, 8'hFF, 8'h00);
    op_a = 8'hC3;
    op_b = 8'h01;
    bus.instr = 8'h81;
    bus.instr_valid = 1'b1;
    hs_pend = bus.instr_ready;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      if (bus.dest_we_a) wq.push_back(1'b0);
      if (bus.dest_we_d) wq.push_back(1'b1);
      if (hs_pend) begin
        hs_c.push_back(cyc);
        if (hs_c.size() == 1) bus.instr = 8'h8E;
        else bus.instr_valid = 1'b0;
      end
      hs_pend = bus.instr_ready && bus.instr_valid;
    end
    bus.instr_valid = 1'b0;
    check("b2b_hs", hs_c.size(), 2);
    check("b2b_gap", hs_c.size() == 2 ? hs_c[1] - hs_c[0] : 0, S + 2);
    check("b2b_wr_n", wq.size(), 2);
    check("b2b_order", wq.size() == 2 ? {wq[0], wq[1]} : 2'b11, 2'b01);
    expect_result(8'h8E, op_a, op_b, r, c);
    m_s = r[7];
    m_z = r == 8'h00;
    m_c = c;
    check("b2b_data", bus.dest_data, r);
    check_flags("b2b_flags");
    for (int k = 0; k < 40; k++) begin
      ins = 8'($urandom);
      if (k % 5 != 0) ins[7:4] = 4'b1000;
      run_instr(ins, 8'($urandom), 8'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
